// File: rtl/d2f_pkg.sv
// Shared encodings and constants for the double-to-float conversion arbiter.
package d2f_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam int unsigned FLAG_TIMEOUT   = 3;
  localparam int unsigned FLAG_NAN       = 2;
  localparam int unsigned FLAG_OVERFLOW  = 1;
  localparam int unsigned FLAG_UNDERFLOW = 0;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam int unsigned DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the pointer moves to the losing side after each grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    if (en) begin
      if (req == 2'b11) gnt = ptr_q ? 2'b10 : 2'b01;
      else              gnt = req;
      if (gnt[0])      ptr_d = 1'b1;
      else if (gnt[1]) ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/d2f_arbiter.sv
// Shares one external double-to-float converter between two requesters,
// restarting it per conversion and abandoning it after TIMEOUT wait cycles.
module d2f_arbiter
  import d2f_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_double,
  input  logic [1:0]  req0_rounding,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_double,
  input  logic [1:0]  req1_rounding,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_float,
  output logic [3:0]  rsp_flags,
  output logic        cvt_reset_n,
  output logic [63:0] cvt_double,
  output logic [1:0]  cvt_rounding,
  input  logic        cvt_done,
  input  logic [31:0] cvt_float,
  input  logic        cvt_nan,
  input  logic        cvt_overflow,
  input  logic        cvt_underflow
);

  localparam logic [4:0] TO_CNT = 5'(TIMEOUT);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] op_q, op_d;
  logic [1:0]  rnd_q, rnd_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_float_q, rsp_float_d;
  logic [3:0]  rsp_flags_q, rsp_flags_d;
  logic [1:0]  gnt;
  logic [3:0]  done_flags;

  rr_arb2 u_rr (
    .clk   (clk),
    .reset (reset),
    .en    ((state_q == ST_IDLE) && !reset),
    .req   ({req1_valid, req0_valid}),
    .gnt   (gnt)
  );

  assign req0_ready   = gnt[0];
  assign req1_ready   = gnt[1];
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_id       = rsp_id_q;
  assign rsp_float    = rsp_float_q;
  assign rsp_flags    = rsp_flags_q;
  assign cvt_reset_n  = (state_q == ST_WAIT);
  assign cvt_double   = op_q;
  assign cvt_rounding = rnd_q;

  always_comb begin
    done_flags                 = '0;
    done_flags[FLAG_NAN]       = cvt_nan;
    done_flags[FLAG_OVERFLOW]  = cvt_overflow;
    done_flags[FLAG_UNDERFLOW] = cvt_underflow;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    rnd_d       = rnd_q;
    rsp_id_d    = rsp_id_q;
    rsp_float_d = rsp_float_q;
    rsp_flags_d = rsp_flags_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          op_d     = gnt[1] ? req1_double   : req0_double;
          rnd_d    = gnt[1] ? req1_rounding : req0_rounding;
          rsp_id_d = gnt[1];
          cnt_d    = '0;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 5'd1;
        // A completion in the timeout cycle still wins over the abandon path.
        if (cvt_done) begin
          rsp_float_d = cvt_float;
          rsp_flags_d = done_flags;
          state_d     = ST_RESP;
        end else if (cnt_q == TO_CNT) begin
          rsp_float_d               = QNAN;
          rsp_flags_d               = '0;
          rsp_flags_d[FLAG_TIMEOUT] = 1'b1;
          state_d                   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      rnd_q       <= '0;
      rsp_id_q    <= 1'b0;
      rsp_float_q <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      rnd_q       <= rnd_d;
      rsp_id_q    <= rsp_id_d;
      rsp_float_q <= rsp_float_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

endmodule

// File: doc/d2f_arbiter.md
D2F_ARBITER -- requirements
Module: d2f_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, the maximum number of WAIT cycles before a conversion is abandoned.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports reqN_valid, input, 1, requester N (N=0,1) has a conversion pending.
REQ-005 SHALL have ports reqN_ready, output, 1, requester N's request is accepted this cycle.
REQ-006 SHALL have ports reqN_double, input, 64, requester N's operand.
REQ-007 SHALL have ports reqN_rounding, input, 2, requester N's rounding mode.
REQ-008 SHALL have port rsp_valid, output, 1, result available.
REQ-009 SHALL have port rsp_ready, input, 1, consumer takes the result.
REQ-010 SHALL have port rsp_id, output, 1, index of the requester owning the result.
REQ-011 SHALL have port rsp_float, output, 32, converted value.
REQ-012 SHALL have port rsp_flags, output, 4, {timeout, nan, overflow, underflow}.
REQ-013 SHALL have port cvt_reset_n, output, 1, active-low restart to the converter.
REQ-014 SHALL have port cvt_double, output, 64, operand to the converter.
REQ-015 SHALL have port cvt_rounding, output, 2, rounding mode to the converter.
REQ-016 SHALL have ports cvt_done, cvt_float (32), cvt_nan, cvt_overflow and cvt_underflow, all inputs, converter results.

Function
REQ-017 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE, 2-bit encoding.
REQ-018 SHALL, in IDLE with any reqN_valid, assert exactly one reqN_ready combinationally, selected round-robin.
REQ-019 SHALL keep a priority pointer, reset 0: both valid -> grant the pointer side; one valid -> grant it.
REQ-020 SHALL set the pointer to the non-granted index after every accept (valid & ready).
REQ-021 SHALL, on accept, latch operand, rounding and id into internal registers, clear the counter and enter WAIT next cycle.
REQ-022 SHALL drive cvt_double/cvt_rounding from the latched registers, stable for the whole of WAIT.
REQ-023 SHALL drive cvt_reset_n=1 only in WAIT and 0 in all other states, so each conversion restarts the converter.
REQ-024 SHALL, in WAIT, increment the 5-bit counter each cycle.
REQ-025 SHALL, on cvt_done=1 in WAIT, capture cvt_float and the three flags with timeout=0, then enter RESP.
REQ-026 SHALL, when the counter equals TIMEOUT with cvt_done=0, load rsp_float=32'h7FC00000 and flags=4'b1000, then enter RESP.
REQ-027 SHALL give priority to cvt_done when cvt_done and timeout occur in the same cycle.
REQ-028 SHALL ignore cvt_done outside WAIT.
REQ-029 SHALL, in RESP, hold rsp_valid=1 and rsp_* stable until rsp_ready=1, then return to IDLE next cycle.
REQ-030 SHALL deassert both reqN_ready outside IDLE; new requests wait without being dropped.
REQ-031 SHALL give a latency of accept to rsp_valid of (cycles to cvt_done in WAIT)+1; minimum 2 cycles.

Reset
REQ-032 SHALL, on reset=1 at a clock edge, go to IDLE, set pointer=0, counter=0, rsp_valid=0, rsp_id=0, rsp_float=0, rsp_flags=0 and cvt_reset_n=0.
REQ-033 SHALL, on reset mid-WAIT or mid-RESP, abandon the in-flight result with no response.
REQ-034 SHALL keep reqN_ready=0 while reset=1.

Structure
REQ-035 SHALL place state encoding, flag bit indices, the QNAN constant 32'h7FC00000 and the default TIMEOUT in package d2f_pkg.
REQ-036 SHALL implement the two-way round-robin grant and pointer as sub-module rr_arb2.
REQ-037 SHALL keep the converter outside this block; d2f_arbiter only sequences it.

Verification
REQ-038 SHALL check: req0 only, double 64'h3FF0000000000000, rounding 0, converter model done after 4 cycles -> rsp_id=0, rsp_float=32'h3F800000, flags=0.
REQ-039 SHALL check: req0 and req1 both valid from reset -> req0 granted first, then req1; rsp_id sequence 0,1.
REQ-040 SHALL check: both valid continuously for 4 conversions -> grants alternate 0,1,0,1.
REQ-041 SHALL check: converter model never asserts done -> after 15 WAIT cycles, rsp_float=32'h7FC00000, flags=4'b1000, cvt_reset_n returns to 0.
REQ-042 SHALL check: rsp_ready held low for 10 cycles -> rsp held stable, reqN_ready=0 throughout; accept resumes after rsp_ready=1.
REQ-043 SHALL check: reset asserted in WAIT -> next cycle IDLE, rsp_valid=0, cvt_reset_n=0, pointer=0.
